gate_bist_ctrl: RTL

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input gate.
// Walks all four input vectors and compares the gate output with a truth table.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] exp_tt,
    input  logic       dut_y,
    output logic       drv_a,
    output logic       drv_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] APPLY = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [3:0] tt_q;
    logic       mism;
    logic [3:0] hit;

    assign mism = (dut_y != tt_q[vec_idx]);
    assign hit  = mism ? (4'b0001 << vec_idx) : 4'b0000;

    assign busy  = (state == APPLY) || (state == WAIT) || (state == CHECK);
    assign done  = (state == DONE);
    // Gate inputs are parked low whenever the sequencer is idle.
    assign drv_a = (state != IDLE) && vec_idx[1];
    assign drv_b = (state != IDLE) && vec_idx[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            tt_q     <= 4'd0;
            vec_idx  <= 2'd0;
            pass     <= 1'b0;
            fail_vec <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tt_q     <= exp_tt;
                        fail_vec <= 4'd0;
                        pass     <= 1'b0;
                        vec_idx  <= 2'd0;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state   <= IDLE;
                        pass    <= 1'b0;
                        vec_idx <= 2'd0;
                    end else begin
                        cnt   <= SETTLE;
                        state <= (SETTLE == 8'd0) ? CHECK : WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state   <= IDLE;
                        pass    <= 1'b0;
                        vec_idx <= 2'd0;
                    end else begin
                        if (cnt <= 8'd1) state <= CHECK;
                        if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    end
                end
                CHECK: begin
                    // Abort wins over recording the result of this vector.
                    if (abort) begin
                        state   <= IDLE;
                        pass    <= 1'b0;
                        vec_idx <= 2'd0;
                    end else begin
                        fail_vec <= fail_vec | hit;
                        if (vec_idx == 2'd3) begin
                            pass  <= ((fail_vec | hit) == 4'd0);
                            state <= DONE;
                        end else begin
                            vec_idx <= vec_idx + 2'd1;
                            state   <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
